// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a valid/ready handshake and a two-entry skid
// buffer. in_ready, out_valid and out_data all come straight from flops, so
// neither handshake direction has a combinational path through this stage.
// A synchronous flush empties the stage without touching the data registers.
module pipe_skid_reg #(
  parameter int              WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       level
);

  // The state encoding doubles as the occupancy count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] main_nxt_s;
  logic [WIDTH-1:0] skid_r;
  logic [WIDTH-1:0] skid_nxt_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             push_s;
  logic             pop_s;

  assign push_s    = in_valid & in_ready_r;
  assign pop_s     = out_valid_r & out_ready;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;
  assign level     = state_r;

  // Next-state and data-load selection; flush overrides the handshake and
  // suppresses every data load so a coinciding push is simply dropped.
  always_comb begin
    state_nxt_s = state_r;
    main_nxt_s  = main_r;
    skid_nxt_s  = skid_r;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (push_s) begin
            state_nxt_s = ST_ONE;
            main_nxt_s  = in_data;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (push_s && pop_s) begin
            state_nxt_s = ST_ONE;
            main_nxt_s  = in_data;
          end else if (push_s) begin
            state_nxt_s = ST_TWO;
            skid_nxt_s  = in_data;
          end else if (pop_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a pop can move the stage.
          if (pop_s) begin
            state_nxt_s = ST_ONE;
            main_nxt_s  = skid_r;
          end else begin
            state_nxt_s = ST_TWO;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
        end
      endcase
    end
  end

  // State, data and registered handshake flags; ready/valid are precomputed
  // from the next state so they are exact functions of the registered state.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r     <= ST_EMPTY;
      main_r      <= RESET_VALUE;
      skid_r      <= RESET_VALUE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      main_r      <= main_nxt_s;
      skid_r      <= skid_nxt_s;
      in_ready_r  <= (state_nxt_s != ST_TWO);
      out_valid_r <= (state_nxt_s != ST_EMPTY);
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and randomised self-checking bench for pipe_skid_reg.
module tb_pipe_skid_reg;

  logic        clk;
  logic        clrn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  level;

  int checks_cnt;
  int errors_cnt;

  logic [31:0] model_q[$];

  pipe_skid_reg #(
    .WIDTH      (32),
    .RESET_VALUE(32'hDEAD_BEEF)
  ) dut (
    .clk      (clk),
    .clrn     (clrn),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .level    (level)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic [1:0] exp_level,
                              input logic exp_in_ready, input logic exp_out_valid);
    check_value({tag, "_level"},     {30'd0, level},     {30'd0, exp_level});
    check_value({tag, "_in_ready"},  {31'd0, in_ready},  {31'd0, exp_in_ready});
    check_value({tag, "_out_valid"}, {31'd0, out_valid}, {31'd0, exp_out_valid});
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus and checks.
  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    clrn      = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;

    // Power-on reset values.
    #12;
    check_status("por", 2'd0, 1'b1, 1'b0);
    check_value("por_data", out_data, 32'hDEAD_BEEF);
    step();
    clrn = 1'b1;

    // Streaming: one payload per cycle, each visible one edge after push.
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = i;
      step();
      check_value("stream_data", out_data, i);
      check_status("stream", 2'd1, 1'b1, 1'b1);
    end
    in_valid = 1'b0;
    step();
    check_status("stream_drain", 2'd0, 1'b1, 1'b0);

    // Stall into the skid entry, then release with no gap.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'd10;
    step();
    check_status("stall_one", 2'd1, 1'b1, 1'b1);
    check_value("stall_head10", out_data, 32'd10);
    in_data = 32'd11;
    step();
    check_status("stall_two", 2'd2, 1'b0, 1'b1);
    in_data = 32'd12;
    step();
    check_status("stall_hold", 2'd2, 1'b0, 1'b1);
    check_value("stall_head_held", out_data, 32'd10);
    out_ready = 1'b1;
    step();
    check_value("release_11", out_data, 32'd11);
    check_status("release_a", 2'd1, 1'b1, 1'b1);
    step();
    check_value("release_12", out_data, 32'd12);
    check_status("release_b", 2'd1, 1'b1, 1'b1);
    in_valid = 1'b0;
    step();
    check_status("release_drain", 2'd0, 1'b1, 1'b0);

    // Flush at level 2 with a pending payload 99.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'd20;
    step();
    in_data = 32'd21;
    step();
    check_status("pre_flush2", 2'd2, 1'b0, 1'b1);
    in_data = 32'd99;
    flush   = 1'b1;
    step();
    flush = 1'b0;
    check_status("flush2", 2'd0, 1'b1, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check_status("flush2_quiet", 2'd0, 1'b1, 1'b0);
    end

    // A push coinciding with flush from EMPTY is discarded.
    in_valid = 1'b1;
    in_data  = 32'd77;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_status("flush_push", 2'd0, 1'b1, 1'b0);

    // Flush at level 1 together with a pop: 5 is seen once, then empty.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'd5;
    step();
    in_valid = 1'b0;
    check_value("flush1_head", out_data, 32'd5);
    check_status("flush1_pre", 2'd1, 1'b1, 1'b1);
    out_ready = 1'b1;
    flush     = 1'b1;
    step();
    flush = 1'b0;
    check_status("flush1_post", 2'd0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream at level 2.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'd30;
    step();
    in_data = 32'd31;
    step();
    in_valid = 1'b0;
    check_status("pre_reset", 2'd2, 1'b0, 1'b1);
    #2;
    clrn = 1'b0;
    #1;
    check_status("mid_reset", 2'd0, 1'b1, 1'b0);
    check_value("mid_reset_data", out_data, 32'hDEAD_BEEF);
    #2;
    clrn = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'd40;
    step();
    in_valid = 1'b0;
    check_value("post_reset_push", out_data, 32'd40);
    check_status("post_reset", 2'd1, 1'b1, 1'b1);
    out_ready = 1'b1;
    step();
    check_status("post_reset_drain", 2'd0, 1'b1, 1'b0);

    // Random traffic against a reference queue.
    model_q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic m_push;
      logic m_pop;
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 99) < 2);
      in_data   = $urandom;
      check_status("rnd", model_q.size() == 2 ? 2'd2 : (model_q.size() == 1 ? 2'd1 : 2'd0),
                   model_q.size() != 2, model_q.size() != 0);
      if (model_q.size() != 0) begin
        check_value("rnd_data", out_data, model_q[0]);
      end
      m_push = in_valid && (model_q.size() != 2);
      m_pop  = out_ready && (model_q.size() != 0);
      if (flush) begin
        model_q.delete();
      end else begin
        if (m_pop) begin
          void'(model_q.pop_front());
        end
        if (m_push) begin
          model_q.push_back(in_data);
        end
      end
      step();
    end
    flush    = 1'b0;
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer and a synchronous flush. It generalises the fixed 32-bit clear-on-reset register into a stage that can sit between any two pipeline stages of the CPU (IF/ID, ID/EX, EX/MEM, MEM/WB). It adds three things the plain register lacks:
- back-pressure (stall),
- bubble insertion (flush),
- full throughput with a registered `in_ready`, so there is no combinational ready path across stages.

## Interface
Parameters:
- `WIDTH`, 32, payload width in bits (≥1).
- `RESET_VALUE`, 0, value loaded into both data registers on reset (`WIDTH` bits).

Ports:
- `clk` input 1: clock, all state updates on rising edge.
- `clrn` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous flush; empties the stage.
- `in_valid` input 1: upstream has a payload.
- `in_ready` output 1: stage can accept; registered.
- `in_data` input `WIDTH`: upstream payload.
- `out_valid` output 1: stage holds a payload for downstream; registered.
- `out_ready` input 1: downstream accepts.
- `out_data` output `WIDTH`: payload at the head of the stage; registered.
- `level` output 2: occupancy, 0..2.

## Operation
Internal state:
- `main` register plus valid bit; drives `out_data` and `out_valid`.
- `skid` register plus valid bit.
- State set: EMPTY (level 0), ONE (level 1, `main` only), TWO (level 2, `main` and `skid`).

Handshake:
- `push` = `in_valid & in_ready`.
- `pop` = `out_valid & out_ready`.
- `in_ready` = (state ≠ TWO). It is a function of registered state only.
- `out_valid` = (state ≠ EMPTY).

Transitions when `flush` = 0:
- EMPTY, push → ONE; `main` ← `in_data`.
- EMPTY, no push → EMPTY.
- ONE, push & pop → ONE; `main` ← `in_data`.
- ONE, push & !pop → TWO; `skid` ← `in_data`.
- ONE, !push & pop → EMPTY.
- ONE, neither → ONE, data held.
- TWO (push is impossible) with pop → ONE; `main` ← `skid`.
- TWO, no pop → TWO, data held.

Flush:
- `flush` = 1 has the highest priority: next state is EMPTY, whatever push or pop occur in that cycle.
- A push coinciding with flush counts as consumed by upstream and is discarded.
- A pop coinciding with flush completes normally downstream, because downstream already sampled the data.
- Data registers are not modified by flush.

Other rules:
- When empty, `out_data` holds the last `main` value (downstream must ignore it).
- Payloads leave in arrival order; there is no loss and no duplication except for the flush discard described above.
- Reset (`clrn` = 0, effective immediately, any state, mid-transfer included):
  - state EMPTY, so `out_valid` = 0, `in_ready` = 1, `level` = 0;
  - `main` = `skid` = `RESET_VALUE`, so `out_data` = `RESET_VALUE`.
- Width: payload passes unmodified. There is no arithmetic; `level` is the state encoding.

## Timing
- Latency: a payload pushed at edge N appears on `out_data` with `out_valid` = 1 after edge N (visible in cycle N+1) when the stage was EMPTY, or when it was ONE with a simultaneous pop.
- Throughput: 1 payload/cycle when `out_ready` is held high.
- Stall: when `out_ready` drops, at most one further payload is accepted (into `skid`). `in_ready` falls in the cycle after the stage reaches TWO.
- Release: `in_ready` rises in the cycle after the first pop out of TWO.
- Combinational paths: none from `out_ready` to `in_ready`, and none from inputs to `out_valid` or `out_data`.
- Reset release: the first push can occur in the first cycle after `clrn` goes high.

## Test plan
- Reset: assert `clrn` = 0 mid-stream with level 2 and `RESET_VALUE` = 32'hDEAD_BEEF → immediately `out_valid` = 0, `in_ready` = 1, `level` = 0, `out_data` = 32'hDEAD_BEEF.
- Streaming: push 1, 2, 3, 4 on consecutive cycles with `out_ready` = 1 → `out_data` shows 1, 2, 3, 4 on consecutive cycles, each one cycle after its push; `level` stays 1.
- Stall/skid: push 10, 11, 12 back-to-back with `out_ready` = 0 → 10 and 11 are accepted, `level` = 2, `in_ready` = 0 and 12 is held upstream. Raise `out_ready` → outputs are 10, 11, 12 in order with no gap after the release.
- Flush:
  - At level 2, assert `flush` with `in_valid` = 1 (data 99) → next cycle `level` = 0, `out_valid` = 0, 99 is never output.
  - At level 1 (data 5), assert `flush` with pop → 5 is observed once downstream, then the stage is empty.
- Random: 10k cycles of random `in_valid`, `out_ready` and a 2% `flush` rate, checked against a reference queue model → in-order delivery, no loss outside flush, `level` always matches the model, `in_ready` never high at level 2.
